mlp_dp_sequencer: RTL
=====================

# mlp_dp_sequencer

Controller that sequences one `dot_product_16_8x8_multi` datapath (through its MLP wrapper) for a conv2d job. It has two phases. First it streams weight words into the MLP block RAMs. Then it streams activation beats with first/last framing and matching BRAM read addresses, and counts returned sums to detect job completion. It sits between the NoC-facing weight/activation FIFOs and the MLP wrapper.

## Interface
Parameters:
- `IN_DATA_WIDTH`, 144, activation beat width (same as wrapper `mlp_din`)
- `BRAM_ADDR_WIDTH`, 10, BRAM write address width; read address is one bit narrower
- `BRAM_DATA_WIDTH`, 64, weight word width
- `NUM_MLP`, 4, MLP blocks written per load; legal range 1..128
- `A_DELAY`, 2, cycles `mlp_din`/sof/eof lag `bram_rd_addr`
- `OUT_CNT_WIDTH`, 16, width of the output-count config and counters

Ports:
- `clk` in 1: single clock
- `reset_n` in 1: asynchronous assert, active-low reset
- `cfg_start` in 1: start pulse, honoured only in IDLE
- `cfg_skip_load` in 1: reuse the resident weights and skip LOAD
- `cfg_taps` in BRAM_ADDR_WIDTH-1: 16-byte chunks per dot product, 1..511
- `cfg_num_out` in OUT_CNT_WIDTH: dot products in the job, ≥1
- `busy` out 1: high from the cycle after an accepted start until DONE
- `done` out 1: one-cycle completion pulse
- `cfg_err` out 1: one-cycle pulse when a start is rejected
- `wt_data` in BRAM_DATA_WIDTH: weight word
- `wt_valid` in 1: weight word valid
- `wt_ready` out 1: weight word accepted when valid & ready
- `act_data` in IN_DATA_WIDTH: activation beat
- `act_valid` in 1: activation beat valid
- `act_ready` out 1: activation beat accepted when valid & ready
- `bram_din` out BRAM_DATA_WIDTH: BRAM write data
- `bram_wr_addr` out BRAM_ADDR_WIDTH: BRAM write address
- `bram_blk_wr_addr` out 7: BRAM block select
- `bram_wren` out 1: BRAM write enable
- `bram_rd_addr` out BRAM_ADDR_WIDTH-1: BRAM read address
- `mlp_din` out IN_DATA_WIDTH: activation data to the MLP
- `mlp_din_sof` out 1: first chunk of a dot product
- `mlp_din_eof` out 1: last chunk of a dot product
- `dout_valid0` in 1: column-0 `dout_valid` from the wrapper; one pulse per completed sum

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- **IDLE**
  - `cfg_start` with `cfg_taps==0` or `cfg_num_out==0` pulses `cfg_err` next cycle and the block stays in IDLE.
  - Otherwise config is latched. Next state is COMPUTE if `cfg_skip_load`, else LOAD.
- **LOAD**
  - `wt_ready=1`.
  - Each handshake writes one word. Word counter `w` runs 0..2*taps-1 and block counter `b` runs 0..NUM_MLP-1, with `w` inner.
  - Output: `bram_wr_addr=w`, `bram_blk_wr_addr=b`.
  - Goes to COMPUTE after the handshake with w=2*taps-1 and b=NUM_MLP-1.
- **COMPUTE**
  - `act_ready=1` while issued dot products < num_out.
  - Each handshake issues one chunk with tap counter `t` (0..taps-1), `bram_rd_addr=t`, sof=(t==0), eof=(t==taps-1).
  - Issued-count increments on eof. After the last eof, next state is DRAIN.
- **Bubbles:** a cycle with no handshake drives `mlp_din=0`, sof=0, eof=0 through the delay line. Zero data adds nothing to the accumulation, so gaps are legal mid-dot-product.
- **Result counter:** increments on `dout_valid0` in COMPUTE and DRAIN.
- **DRAIN:** goes to DONE when result count == num_out. Pulses arriving in IDLE are ignored.
- **DONE:** `done=1` for one cycle, then IDLE.
- `cfg_start` outside IDLE is ignored, with no `cfg_err`.
- **Reset mid-operation:** returns to IDLE and clears all counters and delay stages. Partial BRAM contents are undefined; the next job must not use `cfg_skip_load`.

## Timing
- **Reset values:** all outputs 0, including `mlp_din`, `bram_din` and the address outputs.
- IDLE→LOAD/COMPUTE: one cycle after the accepted `cfg_start`. `busy` rises in the same cycle.
- **Write path:** handshake at cycle n gives `bram_wren`/data/addresses at n+1, all registered. `wt_ready` drops in the cycle LOAD exits.
- **Read path:** handshake at n gives `bram_rd_addr` at n+1, and `mlp_din`/sof/eof at n+1+A_DELAY.
- `act_ready` is a registered function of state and issued-count. It is never high in the cycle after the last eof handshake.
- Minimum job (skip_load, taps=1, num_out=1, MLP latency L): done = start + 3 + A_DELAY + L, approximately.
- `dout_valid0` coincident with the final issue is counted.

## Structure
- Package `mlp_seq_pkg`: state enum `t_seq_state`, `MLP_BLK_ADDR_W=7`, a helper function for the read address width.
- Sub-module `mlp_seq_delay`: parameterised A_DELAY-stage register pipe for {data, sof, eof}, async reset, A_DELAY=0 passthrough.

## Test plan
- **Load:** NUM_MLP=4, taps=3, continuous `wt_valid` → 24 writes with blk 0,0,0,0,0,0,1,…,3 and wr_addr 0..5 per block; `wt_ready` low after the 24th.
- **Compute, no stalls:** skip_load, taps=4, num_out=2 → rd_addr 0,1,2,3,0,1,2,3; sof on beats 0 and 4, eof on beats 3 and 7, each A_DELAY after its rd_addr. Model returns 2 `dout_valid0` → `done` pulse.
- **Stalls:** randomly deassert `act_valid` (taps=5, num_out=3) → zero bubbles with sof/eof=0; model sums equal the golden dot products.
- **Bad config:** start with taps=0 → `cfg_err` pulse, `busy` stays 0. Start while busy → ignored.
- **Reset mid-operation:** assert `reset_n` low mid-LOAD → all outputs 0 immediately. A new job after reset completes normally.
- **Result timing:** `dout_valid0` pulses during COMPUTE and DRAIN are counted exactly num_out=16 times before `done`; `done` is never pulsed early.

Source files
------------

// File: rtl/mlp_seq_pkg.sv
// mlp_seq_pkg
// Shared types and constants for the MLP dot-product sequencer.
//   t_seq_state    : controller phase (idle, weight load, compute, drain, done)
//   MLP_BLK_ADDR_W : width of the BRAM block-select field on the MLP wrapper
//   rdAddrWidth()  : BRAM read-port address width derived from the write width
package mlp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } t_seq_state;

  localparam int MLP_BLK_ADDR_W = 7;

  // The read port sees 128-bit rows made of two 64-bit write words, so it
  // needs one address bit fewer than the write port.
  function automatic int rdAddrWidth(input int wrAddrWidth);
    return wrAddrWidth - 1;
  endfunction

endpackage

// File: rtl/mlp_seq_delay.sv
// mlp_seq_delay
// Fixed-latency register pipe that lines the activation data and its
// first/last framing up with the BRAM read data inside the MLP wrapper.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   data_i/sof_i/eof_i : beat entering the pipe
//   data_o/sof_o/eof_o : same beat DEPTH cycles later (DEPTH=0 is a wire)
module mlp_seq_delay #(
  parameter int DATA_W = 144,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sof_i,
  input  logic              eof_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sof_o,
  output logic              eof_o
);

  localparam int W = DATA_W + 2;

  generate
    if (DEPTH == 0) begin : gPass
      assign data_o = data_i;
      assign sof_o  = sof_i;
      assign eof_o  = eof_i;
    end else begin : gPipe
      logic [W-1:0] pipe_q [DEPTH];

      // Shift every stage each cycle; bubbles enter as zeros upstream, so
      // no enable is needed here.
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= {sof_i, eof_i, data_i};
          for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign {sof_o, eof_o, data_o} = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mlp_dp_sequencer.sv
// mlp_dp_sequencer
// Drives one MLP dot-product wrapper through a conv2d job: first writes the
// weight words into every MLP block RAM, then streams activation chunks with
// sof/eof framing and matching BRAM read addresses, and finally waits for the
// expected number of column-0 results before pulsing done.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   cfg_start/skip_load/taps/num_out : job configuration, sampled in IDLE
//   busy, done, cfg_err          : job status
//   wt_data/valid/ready          : weight word stream from the NoC FIFO
//   act_data/valid/ready         : activation beat stream from the NoC FIFO
//   bram_din/wr_addr/blk_wr_addr/wren : BRAM write port of the wrapper
//   bram_rd_addr                 : BRAM read address
//   mlp_din/sof/eof              : activation chunk into the wrapper
//   dout_valid0                  : one pulse per finished dot product
module mlp_dp_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int IN_DATA_WIDTH   = 144,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int BRAM_DATA_WIDTH = 64,
  parameter int NUM_MLP         = 4,
  parameter int A_DELAY         = 2,
  parameter int OUT_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_start,
  input  logic                       cfg_skip_load,
  input  logic [BRAM_ADDR_WIDTH-2:0] cfg_taps,
  input  logic [OUT_CNT_WIDTH-1:0]   cfg_num_out,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  input  logic [BRAM_DATA_WIDTH-1:0] wt_data,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [IN_DATA_WIDTH-1:0]   act_data,
  input  logic                       act_valid,
  output logic                       act_ready,
  output logic [BRAM_DATA_WIDTH-1:0] bram_din,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [6:0]                 bram_blk_wr_addr,
  output logic                       bram_wren,
  output logic [BRAM_ADDR_WIDTH-2:0] bram_rd_addr,
  output logic [IN_DATA_WIDTH-1:0]   mlp_din,
  output logic                       mlp_din_sof,
  output logic                       mlp_din_eof,
  input  logic                       dout_valid0
);

  localparam int RD_W = rdAddrWidth(BRAM_ADDR_WIDTH);
  localparam logic [MLP_BLK_ADDR_W-1:0] BLK_LAST = MLP_BLK_ADDR_W'(NUM_MLP - 1);

  t_seq_state state_q, state_d;

  logic [RD_W-1:0]            taps_q, taps_d;
  logic [OUT_CNT_WIDTH-1:0]   numOut_q, numOut_d;
  logic [BRAM_ADDR_WIDTH-1:0] wCnt_q, wCnt_d;
  logic [MLP_BLK_ADDR_W-1:0]  bCnt_q, bCnt_d;
  logic [RD_W-1:0]            tCnt_q, tCnt_d;
  logic [OUT_CNT_WIDTH-1:0]   issued_q, issued_d;
  logic [OUT_CNT_WIDTH-1:0]   results_q, results_d;
  logic                       actReady_q, actReady_d;
  logic                       cfgErr_q, cfgErr_d;
  logic                       bramWren_q, bramWren_d;
  logic [BRAM_DATA_WIDTH-1:0] bramDin_q, bramDin_d;
  logic [BRAM_ADDR_WIDTH-1:0] bramWrAddr_q, bramWrAddr_d;
  logic [MLP_BLK_ADDR_W-1:0]  bramBlk_q, bramBlk_d;
  logic [RD_W-1:0]            rdAddr_q, rdAddr_d;
  logic [IN_DATA_WIDTH-1:0]   s0Data_q, s0Data_d;
  logic                       s0Sof_q, s0Sof_d;
  logic                       s0Eof_q, s0Eof_d;

  logic [BRAM_ADDR_WIDTH-1:0] wLast;
  logic [RD_W-1:0]            tLast;
  logic                       wtFire;
  logic                       actFire;

  // Each block holds 2*taps 64-bit words because one 16-byte chunk spans two.
  assign wLast   = {taps_q, 1'b0} - BRAM_ADDR_WIDTH'(1);
  assign tLast   = taps_q - RD_W'(1);
  assign wtFire  = wt_valid && wt_ready;
  assign actFire = act_valid && actReady_q;

  // Next-state and datapath-register logic. The stage-0 activation register
  // lines up with bram_rd_addr; a cycle with no handshake pushes a zero
  // bubble so a stalled dot product accumulates nothing extra.
  always_comb begin
    state_d      = state_q;
    taps_d       = taps_q;
    numOut_d     = numOut_q;
    wCnt_d       = wCnt_q;
    bCnt_d       = bCnt_q;
    tCnt_d       = tCnt_q;
    issued_d     = issued_q;
    results_d    = results_q;
    cfgErr_d     = 1'b0;
    bramWren_d   = 1'b0;
    bramDin_d    = bramDin_q;
    bramWrAddr_d = bramWrAddr_q;
    bramBlk_d    = bramBlk_q;
    rdAddr_d     = rdAddr_q;
    s0Data_d     = '0;
    s0Sof_d      = 1'b0;
    s0Eof_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_taps == '0 || cfg_num_out == '0) begin
            cfgErr_d = 1'b1;
          end else begin
            taps_d    = cfg_taps;
            numOut_d  = cfg_num_out;
            wCnt_d    = '0;
            bCnt_d    = '0;
            tCnt_d    = '0;
            issued_d  = '0;
            results_d = '0;
            state_d   = cfg_skip_load ? ST_COMPUTE : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (wtFire) begin
          bramWren_d   = 1'b1;
          bramDin_d    = wt_data;
          bramWrAddr_d = wCnt_q;
          bramBlk_d    = bCnt_q;
          if (wCnt_q == wLast) begin
            wCnt_d = '0;
            if (bCnt_q == BLK_LAST) begin
              bCnt_d  = '0;
              state_d = ST_COMPUTE;
            end else begin
              bCnt_d = bCnt_q + MLP_BLK_ADDR_W'(1);
            end
          end else begin
            wCnt_d = wCnt_q + BRAM_ADDR_WIDTH'(1);
          end
        end
      end
      ST_COMPUTE: begin
        if (actFire) begin
          rdAddr_d = tCnt_q;
          s0Data_d = act_data;
          s0Sof_d  = (tCnt_q == '0);
          s0Eof_d  = (tCnt_q == tLast);
          if (tCnt_q == tLast) begin
            tCnt_d   = '0;
            issued_d = issued_q + OUT_CNT_WIDTH'(1);
            if (issued_d == numOut_q) begin
              state_d = ST_DRAIN;
            end
          end else begin
            tCnt_d = tCnt_q + RD_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (results_q == numOut_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (dout_valid0 && (state_q == ST_COMPUTE || state_q == ST_DRAIN)) begin
      results_d = results_q + OUT_CNT_WIDTH'(1);
    end

    // Computed from the next state so ready is already low in the cycle
    // after the final eof handshake.
    actReady_d = (state_d == ST_COMPUTE) && (issued_d < numOut_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      taps_q       <= '0;
      numOut_q     <= '0;
      wCnt_q       <= '0;
      bCnt_q       <= '0;
      tCnt_q       <= '0;
      issued_q     <= '0;
      results_q    <= '0;
      actReady_q   <= 1'b0;
      cfgErr_q     <= 1'b0;
      bramWren_q   <= 1'b0;
      bramDin_q    <= '0;
      bramWrAddr_q <= '0;
      bramBlk_q    <= '0;
      rdAddr_q     <= '0;
      s0Data_q     <= '0;
      s0Sof_q      <= 1'b0;
      s0Eof_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      taps_q       <= taps_d;
      numOut_q     <= numOut_d;
      wCnt_q       <= wCnt_d;
      bCnt_q       <= bCnt_d;
      tCnt_q       <= tCnt_d;
      issued_q     <= issued_d;
      results_q    <= results_d;
      actReady_q   <= actReady_d;
      cfgErr_q     <= cfgErr_d;
      bramWren_q   <= bramWren_d;
      bramDin_q    <= bramDin_d;
      bramWrAddr_q <= bramWrAddr_d;
      bramBlk_q    <= bramBlk_d;
      rdAddr_q     <= rdAddr_d;
      s0Data_q     <= s0Data_d;
      s0Sof_q      <= s0Sof_d;
      s0Eof_q      <= s0Eof_d;
    end
  end

  mlp_seq_delay #(
    .DATA_W(IN_DATA_WIDTH),
    .DEPTH (A_DELAY)
  ) uDelay (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .data_i  (s0Data_q),
    .sof_i   (s0Sof_q),
    .eof_i   (s0Eof_q),
    .data_o  (mlp_din),
    .sof_o   (mlp_din_sof),
    .eof_o   (mlp_din_eof)
  );

  assign busy             = (state_q == ST_LOAD) || (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
  assign done             = (state_q == ST_DONE);
  assign wt_ready         = (state_q == ST_LOAD);
  assign act_ready        = actReady_q;
  assign cfg_err          = cfgErr_q;
  assign bram_wren        = bramWren_q;
  assign bram_din         = bramDin_q;
  assign bram_wr_addr     = bramWrAddr_q;
  assign bram_blk_wr_addr = bramBlk_q;
  assign bram_rd_addr     = rdAddr_q;

endmodule
